// File: rtl/ib_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ib_ctrl_pkg
// Shared types and helpers for the vector input buffer controller.
//   ib_state_t   : frame-sequencing state (IDLE, STREAM, DRAIN)
//   IB_DEPTH_DEF : default number of vector RAM entries
//   CNT_W_DEF    : default drop counter width
//   ptr_inc()    : pointer increment with explicit wrap at depth-1, so
//                  depths that are not a power of two work unchanged
// ---------------------------------------------------------------------------
package ib_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } ib_state_t;

  localparam int IB_DEPTH_DEF = 4;
  localparam int CNT_W_DEF    = 16;

  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Width-parameterised event counter that sticks at all-ones instead of
// wrapping.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, clears the count
//   inc_i   : count one event this cycle
//   count_o : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Hold at all-ones once reached so the count never rolls back to a
  // misleadingly small value.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/input_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// input_buffer_ctrl
// Pointer, occupancy and frame-sequencing controller for the vector input
// buffer. The vector RAM lives outside; this block drives its addresses and
// write strobe and keeps one eof bit per entry. The upstream datapath cannot
// be stalled, so vectors that cannot be stored are dropped. Once an eof
// vector is accepted the buffer refuses new input until that frame drains.
//
// Optional feature macro: IB_CTRL_DROP_CNT_EN
//   defined   -> drop_cnt port and saturating drop counter present
//   undefined -> drops are silent, no counter logic
//
// Ports:
//   clk        : single clock, rising edge
//   reset_n    : asynchronous active-low reset
//   valid_in   : upstream vector valid
//   eof_in     : vector is last of frame (qualified by valid_in)
//   next_in    : downstream requests one vector
//   wr_en      : RAM write strobe (combinational, = accept)
//   wr_addr    : RAM write address (head)
//   rd_addr    : RAM read address (tail)
//   valid_out  : RAM read data valid, one cycle after the pop
//   eof_out    : eof bit of the popped entry, with valid_out
//   frame_done : one-cycle pulse when the eof entry of a frame is delivered
//   full/empty : from registered occupancy
//   occupancy  : entries currently held
//   drop_cnt   : saturating count of dropped vectors (macro only)
// ---------------------------------------------------------------------------
module input_buffer_ctrl
  import ib_ctrl_pkg::*;
#(
  parameter int   IB_DEPTH = IB_DEPTH_DEF,
  parameter int   PTR_W    = $clog2(IB_DEPTH),
`ifdef IB_CTRL_DROP_CNT_EN
  parameter int   CNT_W    = CNT_W_DEF,
`endif
  localparam int  OCC_W    = $clog2(IB_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic             eof_in,
  input  logic             next_in,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic [PTR_W-1:0] rd_addr,
  output logic             valid_out,
  output logic             eof_out,
  output logic             frame_done,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] occupancy
`ifdef IB_CTRL_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  ib_state_t           state_q, state_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [IB_DEPTH-1:0] eof_q, eof_d;
  logic                valid_out_q;
  logic                eof_out_q;
  logic                frame_done_q;

  logic accept;
  logic pop;
  logic pop_eof;

  assign full  = (occ_q == OCC_W'(IB_DEPTH));
  assign empty = (occ_q == '0);

  // full is evaluated on registered occupancy, so a pop in the same cycle
  // does not make room for a push until the next cycle.
  assign accept  = valid_in & ~full & (state_q != DRAIN);
  assign pop     = next_in & ~empty;
  assign pop_eof = pop & eof_q[tail_q];

  // Pointer, occupancy and per-entry eof bookkeeping.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    eof_d  = eof_q;
    if (accept) begin
      eof_d[head_q] = eof_in;
      head_d        = PTR_W'(ptr_inc(int'(head_q), IB_DEPTH));
    end
    if (pop) begin
      tail_d = PTR_W'(ptr_inc(int'(tail_q), IB_DEPTH));
    end
    case ({accept, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Frame sequencing. While draining, only one eof entry can be in the
  // buffer (no accepts happen in DRAIN), so popping any eof entry ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = eof_in ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (accept && eof_in) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop_eof) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // valid_out/eof_out/frame_done are delayed one cycle to line up with the
  // synchronous RAM read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      occ_q        <= '0;
      eof_q        <= '0;
      valid_out_q  <= 1'b0;
      eof_out_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      eof_q        <= eof_d;
      valid_out_q  <= pop;
      eof_out_q    <= pop_eof;
      frame_done_q <= pop_eof & (state_q == DRAIN);
    end
  end

  assign wr_en      = accept;
  assign wr_addr    = head_q;
  assign rd_addr    = tail_q;
  assign valid_out  = valid_out_q;
  assign eof_out    = eof_out_q;
  assign frame_done = frame_done_q;
  assign occupancy  = occ_q;

`ifdef IB_CTRL_DROP_CNT_EN
  logic drop;

  assign drop = valid_in & ~accept;

  sat_counter #(
    .W(CNT_W)
  ) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (drop),
    .count_o (drop_cnt)
  );
`endif

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_input_buffer_ctrl
// Self-checking bench for input_buffer_ctrl. A queue-based reference model
// holds the buffered entries (address + eof) and a draining flag; expected
// outputs are derived from it each cycle. Directed scenarios come first,
// then a randomized run. Drop counter checks exist only when
// IB_CTRL_DROP_CNT_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_input_buffer_ctrl;

  localparam int Depth = 4;
  localparam int PtrW  = $clog2(Depth);
  localparam int OccW  = $clog2(Depth + 1);
  localparam int CntW  = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            valid_in;
  logic            eof_in;
  logic            next_in;
  logic            wr_en;
  logic [PtrW-1:0] wr_addr;
  logic [PtrW-1:0] rd_addr;
  logic            valid_out;
  logic            eof_out;
  logic            frame_done;
  logic            full;
  logic            empty;
  logic [OccW-1:0] occupancy;
`ifdef IB_CTRL_DROP_CNT_EN
  logic [CntW-1:0] drop_cnt;
`endif

  int checks = 0;
  int passes = 0;

  typedef struct {
    int addr;
    bit eof;
  } entry_t;

  entry_t modelQ[$];
  int     modelHead;
  int     modelTail;
  bit     modelDrain;
  int     modelDrops;

  bit expWrEn;
  int expWrAddr;
  int expRdAddr;
  int expOcc;
  bit expFull;
  bit expEmpty;
  bit expVout;
  bit expEofOut;
  bit expFrameDone;

  always #5 clk = ~clk;

  input_buffer_ctrl #(
    .IB_DEPTH(Depth)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_in   (valid_in),
    .eof_in     (eof_in),
    .next_in    (next_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .valid_out  (valid_out),
    .eof_out    (eof_out),
    .frame_done (frame_done),
    .full       (full),
    .empty      (empty),
    .occupancy  (occupancy)
`ifdef IB_CTRL_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  // Model back to its post-reset contents.
  task automatic modelReset();
    modelQ.delete();
    modelHead    = 0;
    modelTail    = 0;
    modelDrain   = 0;
    modelDrops   = 0;
    expVout      = 0;
    expEofOut    = 0;
    expFrameDone = 0;
  endtask

  // Called at posedge+1: drive inputs, derive the combinational
  // expectations from the model, and settle to mid-cycle.
  task automatic applyStimulus(input bit v, input bit e, input bit n);
    valid_in  = v;
    eof_in    = e;
    next_in   = n;
    expWrEn   = v && (modelQ.size() < Depth) && !modelDrain;
    expWrAddr = modelHead;
    expRdAddr = modelTail;
    expOcc    = modelQ.size();
    expFull   = (modelQ.size() == Depth);
    expEmpty  = (modelQ.size() == 0);
    #3;
  endtask

  // Advance the model by one clock using the driven inputs, then move the
  // DUT across the same edge and return at posedge+1.
  task automatic advanceCycle();
    bit     acc;
    bit     pp;
    entry_t ent;
    acc = valid_in && (modelQ.size() < Depth) && !modelDrain;
    pp  = next_in && (modelQ.size() > 0);
    expVout      = 0;
    expEofOut    = 0;
    expFrameDone = 0;
    if (pp) begin
      ent          = modelQ.pop_front();
      expVout      = 1;
      expEofOut    = ent.eof;
      expFrameDone = ent.eof;
      if (ent.eof) modelDrain = 0;
      modelTail = (modelTail + 1) % Depth;
    end
    if (acc) begin
      ent.addr = modelHead;
      ent.eof  = eof_in;
      modelQ.push_back(ent);
      modelHead = (modelHead + 1) % Depth;
      if (eof_in) modelDrain = 1;
    end else if (valid_in && (modelDrops < (1 << CntW) - 1)) begin
      modelDrops++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset_n  = 1'b0;
    valid_in = 1'b0;
    eof_in   = 1'b0;
    next_in  = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    resetDut();
    checks++; if (valid_out !== 1'b0) $display("[TB] FAIL reset_valid_out: got %0b expected 0", valid_out); else passes++;
    checks++; if (eof_out !== 1'b0) $display("[TB] FAIL reset_eof_out: got %0b expected 0", eof_out); else passes++;
    checks++; if (frame_done !== 1'b0) $display("[TB] FAIL reset_frame_done: got %0b expected 0", frame_done); else passes++;
    checks++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %0b expected 1", empty); else passes++;
    checks++; if (full !== 1'b0) $display("[TB] FAIL reset_full: got %0b expected 0", full); else passes++;
    checks++; if (occupancy !== OccW'(0)) $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); else passes++;
    checks++; if (wr_addr !== PtrW'(0)) $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_addr); else passes++;
    checks++; if (rd_addr !== PtrW'(0)) $display("[TB] FAIL reset_rd_addr: got %0d expected 0", rd_addr); else passes++;
`ifdef IB_CTRL_DROP_CNT_EN
    checks++; if (drop_cnt !== CntW'(0)) $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); else passes++;
`endif
  endtask

  task automatic test_fill();
    resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0);
      checks++; if (wr_en !== 1'b1) $display("[TB] FAIL fill_wr_en[%0d]: got %0b expected 1", i, wr_en); else passes++;
      checks++; if (wr_addr !== PtrW'(i)) $display("[TB] FAIL fill_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, i); else passes++;
      advanceCycle();
    end
    applyStimulus(0, 0, 0);
    checks++; if (occupancy !== OccW'(3)) $display("[TB] FAIL fill_occupancy: got %0d expected 3", occupancy); else passes++;
    checks++; if (empty !== 1'b0) $display("[TB] FAIL fill_empty: got %0b expected 0", empty); else passes++;
    checks++; if (valid_out !== 1'b0) $display("[TB] FAIL fill_valid_out: got %0b expected 0", valid_out); else passes++;
    advanceCycle();
  endtask

  task automatic test_overflow();
    resetDut();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0);
      checks++; if (wr_en !== (i < 4)) $display("[TB] FAIL overflow_wr_en[%0d]: got %0b expected %0b", i, wr_en, (i < 4)); else passes++;
      advanceCycle();
    end
    applyStimulus(0, 0, 0);
    checks++; if (full !== 1'b1) $display("[TB] FAIL overflow_full: got %0b expected 1", full); else passes++;
    checks++; if (occupancy !== OccW'(4)) $display("[TB] FAIL overflow_occupancy: got %0d expected 4", occupancy); else passes++;
`ifdef IB_CTRL_DROP_CNT_EN
    checks++; if (drop_cnt !== CntW'(2)) $display("[TB] FAIL overflow_drop_cnt: got %0d expected 2", drop_cnt); else passes++;
`endif
    advanceCycle();
  endtask

  // Continues from the full buffer left by test_overflow.
  task automatic test_full_push_pop();
    applyStimulus(1, 0, 1);
    checks++; if (wr_en !== 1'b0) $display("[TB] FAIL fullpp_wr_en: got %0b expected 0", wr_en); else passes++;
    checks++; if (rd_addr !== PtrW'(0)) $display("[TB] FAIL fullpp_rd_addr: got %0d expected 0", rd_addr); else passes++;
    advanceCycle();
    applyStimulus(0, 0, 0);
    checks++; if (occupancy !== OccW'(3)) $display("[TB] FAIL fullpp_occupancy: got %0d expected 3", occupancy); else passes++;
    checks++; if (full !== 1'b0) $display("[TB] FAIL fullpp_full: got %0b expected 0", full); else passes++;
    checks++; if (valid_out !== 1'b1) $display("[TB] FAIL fullpp_valid_out: got %0b expected 1", valid_out); else passes++;
`ifdef IB_CTRL_DROP_CNT_EN
    checks++; if (drop_cnt !== CntW'(3)) $display("[TB] FAIL fullpp_drop_cnt: got %0d expected 3", drop_cnt); else passes++;
`endif
    advanceCycle();
  endtask

  // A, B, C(eof), D with popping from the second cycle on.
  task automatic test_frame();
    bit vSeq[4]   = '{1, 1, 1, 1};
    bit eSeq[4]   = '{0, 0, 1, 0};
    bit nSeq[4]   = '{0, 1, 1, 1};
    bit wrExp[4]  = '{1, 1, 1, 0};
    bit voExp[4]  = '{0, 1, 1, 1};
    bit eofExp[4] = '{0, 0, 0, 1};
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vSeq[i], eSeq[i], nSeq[i]);
      checks++; if (wr_en !== wrExp[i]) $display("[TB] FAIL frame_wr_en[%0d]: got %0b expected %0b", i, wr_en, wrExp[i]); else passes++;
      advanceCycle();
      checks++; if (valid_out !== voExp[i]) $display("[TB] FAIL frame_valid_out[%0d]: got %0b expected %0b", i, valid_out, voExp[i]); else passes++;
      checks++; if (eof_out !== eofExp[i]) $display("[TB] FAIL frame_eof_out[%0d]: got %0b expected %0b", i, eof_out, eofExp[i]); else passes++;
      checks++; if (frame_done !== eofExp[i]) $display("[TB] FAIL frame_done[%0d]: got %0b expected %0b", i, frame_done, eofExp[i]); else passes++;
    end
    applyStimulus(1, 0, 0);
    checks++; if (empty !== 1'b1) $display("[TB] FAIL frame_empty_after: got %0b expected 1", empty); else passes++;
    checks++; if (wr_en !== 1'b1) $display("[TB] FAIL frame_readmit_wr_en: got %0b expected 1", wr_en); else passes++;
`ifdef IB_CTRL_DROP_CNT_EN
    checks++; if (drop_cnt !== CntW'(1)) $display("[TB] FAIL frame_drop_cnt: got %0d expected 1", drop_cnt); else passes++;
`endif
    advanceCycle();
    checks++; if (frame_done !== 1'b0) $display("[TB] FAIL frame_done_pulse: got %0b expected 0", frame_done); else passes++;
  endtask

  // Ten pushes, each popped on the following cycle.
  task automatic test_wrap();
    resetDut();
    for (int i = 0; i <= 10; i++) begin
      applyStimulus(i < 10, 0, i > 0);
      if (i < 10) begin
        checks++; if (wr_en !== 1'b1) $display("[TB] FAIL wrap_wr_en[%0d]: got %0b expected 1", i, wr_en); else passes++;
        checks++; if (wr_addr !== PtrW'(i % Depth)) $display("[TB] FAIL wrap_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, i % Depth); else passes++;
      end
      if (i > 0) begin
        checks++; if (rd_addr !== PtrW'((i - 1) % Depth)) $display("[TB] FAIL wrap_rd_addr[%0d]: got %0d expected %0d", i, rd_addr, (i - 1) % Depth); else passes++;
      end
      advanceCycle();
      checks++; if (valid_out !== (i > 0)) $display("[TB] FAIL wrap_valid_out[%0d]: got %0b expected %0b", i, valid_out, (i > 0)); else passes++;
      checks++; if (eof_out !== 1'b0) $display("[TB] FAIL wrap_eof_out[%0d]: got %0b expected 0", i, eof_out); else passes++;
    end
    applyStimulus(0, 0, 1);
    advanceCycle();
    checks++; if (valid_out !== 1'b0) $display("[TB] FAIL wrap_spurious_valid: got %0b expected 0", valid_out); else passes++;
  endtask

  task automatic test_reset_mid_drain();
    resetDut();
    applyStimulus(1, 0, 0);
    advanceCycle();
    applyStimulus(1, 0, 0);
    advanceCycle();
    applyStimulus(1, 1, 1);
    advanceCycle();
    checks++; if (occupancy !== OccW'(2)) $display("[TB] FAIL middrain_pre_occupancy: got %0d expected 2", occupancy); else passes++;
    checks++; if (valid_out !== 1'b1) $display("[TB] FAIL middrain_pre_valid_out: got %0b expected 1", valid_out); else passes++;
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (occupancy !== OccW'(0)) $display("[TB] FAIL middrain_occupancy: got %0d expected 0", occupancy); else passes++;
    checks++; if (empty !== 1'b1) $display("[TB] FAIL middrain_empty: got %0b expected 1", empty); else passes++;
    checks++; if (full !== 1'b0) $display("[TB] FAIL middrain_full: got %0b expected 0", full); else passes++;
    checks++; if (valid_out !== 1'b0) $display("[TB] FAIL middrain_valid_out: got %0b expected 0", valid_out); else passes++;
    checks++; if (eof_out !== 1'b0) $display("[TB] FAIL middrain_eof_out: got %0b expected 0", eof_out); else passes++;
    checks++; if (frame_done !== 1'b0) $display("[TB] FAIL middrain_frame_done: got %0b expected 0", frame_done); else passes++;
    checks++; if (wr_addr !== PtrW'(0)) $display("[TB] FAIL middrain_wr_addr: got %0d expected 0", wr_addr); else passes++;
    checks++; if (rd_addr !== PtrW'(0)) $display("[TB] FAIL middrain_rd_addr: got %0d expected 0", rd_addr); else passes++;
`ifdef IB_CTRL_DROP_CNT_EN
    checks++; if (drop_cnt !== CntW'(0)) $display("[TB] FAIL middrain_drop_cnt: got %0d expected 0", drop_cnt); else passes++;
`endif
    modelReset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1, 0, 0);
    checks++; if (wr_en !== 1'b1) $display("[TB] FAIL middrain_post_wr_en: got %0b expected 1", wr_en); else passes++;
    checks++; if (wr_addr !== PtrW'(0)) $display("[TB] FAIL middrain_post_wr_addr: got %0d expected 0", wr_addr); else passes++;
    advanceCycle();
    checks++; if (occupancy !== OccW'(1)) $display("[TB] FAIL middrain_post_occupancy: got %0d expected 1", occupancy); else passes++;
  endtask

  task automatic test_random();
    bit v;
    bit e;
    bit n;
    resetDut();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 5) == 0);
      n = ($urandom_range(0, 1) == 1);
      applyStimulus(v, e, n);
      checks++; if (wr_en !== expWrEn) $display("[TB] FAIL rand_wr_en cyc %0d: got %0b expected %0b", cyc, wr_en, expWrEn); else passes++;
      checks++; if (wr_addr !== PtrW'(expWrAddr)) $display("[TB] FAIL rand_wr_addr cyc %0d: got %0d expected %0d", cyc, wr_addr, expWrAddr); else passes++;
      checks++; if (rd_addr !== PtrW'(expRdAddr)) $display("[TB] FAIL rand_rd_addr cyc %0d: got %0d expected %0d", cyc, rd_addr, expRdAddr); else passes++;
      checks++; if (occupancy !== OccW'(expOcc)) $display("[TB] FAIL rand_occupancy cyc %0d: got %0d expected %0d", cyc, occupancy, expOcc); else passes++;
      checks++; if (full !== expFull) $display("[TB] FAIL rand_full cyc %0d: got %0b expected %0b", cyc, full, expFull); else passes++;
      checks++; if (empty !== expEmpty) $display("[TB] FAIL rand_empty cyc %0d: got %0b expected %0b", cyc, empty, expEmpty); else passes++;
      advanceCycle();
      checks++; if (valid_out !== expVout) $display("[TB] FAIL rand_valid_out cyc %0d: got %0b expected %0b", cyc, valid_out, expVout); else passes++;
      checks++; if (eof_out !== expEofOut) $display("[TB] FAIL rand_eof_out cyc %0d: got %0b expected %0b", cyc, eof_out, expEofOut); else passes++;
      checks++; if (frame_done !== expFrameDone) $display("[TB] FAIL rand_frame_done cyc %0d: got %0b expected %0b", cyc, frame_done, expFrameDone); else passes++;
`ifdef IB_CTRL_DROP_CNT_EN
      checks++; if (drop_cnt !== CntW'(modelDrops)) $display("[TB] FAIL rand_drop_cnt cyc %0d: got %0d expected %0d", cyc, drop_cnt, modelDrops); else passes++;
`endif
    end
  endtask

  initial begin
    $display("[TB] input_buffer_ctrl bench start");
    test_reset();
    test_fill();
    test_overflow();
    test_full_push_pop();
    test_frame();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
